hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  ID-stage hazard and forwarding controller for the 5-stage PA-RISC pipeline.
//  - Tracks destination register, write enable and load flag of the instructions in EX, MEM and WB.
//  - Drives the S inputs of the ID operand-forwarding muxes (2-bit RP/EX/MEM/WB select).
//  - Drives the S input of MUX_CU (bubble insertion) and the PC / IF-ID load enables.
//  - Resolves load-use stalls and taken-jump squashes.
// PARAMETERS
//  RW            5   register index width (32 GRs)
//  CNT_W         16  width of saturating stall/flush performance counters
//  LOAD_USE_STL  1   1: stall one cycle on load-use; 0: never stall (test only)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  id_ra        in   RW     ID source register A
//  id_rb        in   RW     ID source register B
//  id_ra_use    in   1      ID instruction reads RA
//  id_rb_use    in   1      ID instruction reads RB
//  id_rd        in   RW     ID target register (MUX_ID_IDR output)
//  id_rf_le     in   1      ID instruction writes register file
//  id_load      in   1      ID instruction is a load (L)
//  jump_taken   in   1      EX jump decision (MUX_EX_J output)
//  fw_a_sel     out  2      00 RF, 01 EX, 10 MEM, 11 WB for operand A
//  fw_b_sel     out  2      same encoding for operand B
//  cu_nop       out  1      MUX_CU S: 1 = zero all control signals entering EX
//  pc_le        out  1      PC/nPC load enable
//  if_id_le     out  1      IF/ID register load enable
//  if_flush     out  1      clear IF/ID instruction to NOP next edge
//  stall_cnt    out  CNT_W  load-use stall cycles, saturating
//  flush_cnt    out  CNT_W  taken-jump flushes, saturating
// BEHAVIOUR
//  Tracking pipe: three slots {rd, we, ld} for EX, MEM and WB.
//  - Each edge: WB<=MEM, MEM<=EX, EX<=ID info.
//  - EX is loaded with a bubble (we=0, ld=0, rd=0) when cu_nop=1.
//  - Reset: all slots bubble; both counters 0.
//  - Output values while rst_n=0: fw_*_sel=00, cu_nop=0, pc_le=1, if_id_le=1, if_flush=0.
//  Forwarding (combinational, zero latency):
//  - For each used source s with s!=0, select the first matching slot in the order EX, MEM, WB.
//  - A slot matches when we=1 and rd==s.
//  - Otherwise select 00. GR0 is never forwarded. An unused source always selects 00.
//  - An EX-slot match with ld=1 is not forwardable. It selects 01 only while stalled, which is don't-care.
//  Load-use hazard: ldu = LOAD_USE_STL & EX.we & EX.ld & EX.rd!=0 & (RA or RB match, used).
//  State machine, states RUN and STALL:
//  - RUN -> STALL on ldu & !jump_taken.
//  - STALL -> RUN unconditionally after 1 cycle. By then the load is in MEM and forwards via 10.
//  - In STALL: cu_nop=0, pc_le=1, if_id_le=1.
//  - In RUN: cu_nop=ldu, pc_le=!ldu, if_id_le=!ldu.
//  Jump handling:
//  - jump_taken=1 -> if_flush=1 for that cycle.
//  - The ID instruction is the delay slot and proceeds normally. pc_le=1 so the target is fetched.
//  - ldu and jump_taken cannot coincide (a jump is not a load). If both assert, jump wins: no stall, flush.
//  Counters:
//  - stall_cnt +1 per cycle with cu_nop=1.
//  - flush_cnt +1 per cycle with if_flush=1.
//  - Both saturate at all-ones; no wrap.
//  Reset mid-stall: asynchronous return to RUN with a clean pipe. The next cycle behaves as after power-on.
// TESTING
//  T1 add r3<-..; add ..<-r3,r3 back-to-back -> fw_a_sel=fw_b_sel=01, no stall.
//  T2 writer of r5, 2 unrelated ops, reader of r5 -> sel 11; at distance 2 -> sel 10.
//  T3 ld r7; add ..<-r7 -> 1 cycle with cu_nop=1, pc_le=if_id_le=0, then sel=10, stall_cnt=1.
//  T4 writer r0 then reader r0 -> sel 00, no stall. EX, MEM, WB all write r4 -> sel 01 (EX priority).
//  T5 jump_taken=1 -> if_flush=1 for 1 cycle, flush_cnt+1. Repeat flushes with counter preloaded to 16'hFFFE -> holds at 16'hFFFF.
//  T6 rst_n low during STALL -> outputs at reset values immediately. After release, first reader sees sel 00.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// ID-stage hazard and forwarding controller for the 5-stage pipeline.
// Keeps a small shadow of the destination register, write enable and load
// flag of the instructions now in EX, MEM and WB. It uses that shadow to:
//   - steer the ID operand-forwarding muxes (RF / EX / MEM / WB),
//   - insert a one-cycle bubble on a load-use hazard (MUX_CU + PC/IF-ID hold),
//   - flush the IF/ID instruction when EX resolves a taken jump.
// Two saturating counters record stall cycles and jump flushes.

module hazard_forward_unit #(
    parameter int RW           = 5,
    parameter int CNT_W        = 16,
    parameter int LOAD_USE_STL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RW-1:0]    id_ra,
    input  logic [RW-1:0]    id_rb,
    input  logic             id_ra_use,
    input  logic             id_rb_use,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_rf_le,
    input  logic             id_load,
    input  logic             jump_taken,
    output logic [1:0]       fw_a_sel,
    output logic [1:0]       fw_b_sel,
    output logic             cu_nop,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Forwarding mux select encoding
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    localparam logic [RW-1:0]    REG_ZERO = {RW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Tracking pipe. The load flag only matters while the instruction sits
    // in EX (a load in MEM or WB already has its data), so it is not carried
    // further down the shadow pipe.
    logic [RW-1:0] ex_rd_r;
    logic          ex_we_r;
    logic          ex_ld_r;
    logic [RW-1:0] mem_rd_r;
    logic          mem_we_r;
    logic [RW-1:0] wb_rd_r;
    logic          wb_we_r;

    state_t state_r;
    state_t state_next_s;

    logic             ldu_s;
    logic             cu_nop_s;
    logic             pc_le_s;
    logic             if_id_le_s;
    logic [1:0]       fw_a_sel_s;
    logic [1:0]       fw_b_sel_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Pick the youngest in-flight producer of a source register.
    // GR0 is hard-wired to zero, so it is never forwarded, and a source the
    // instruction does not read always takes the register-file path.
    function automatic logic [1:0] fw_select(
        input logic [RW-1:0] src,
        input logic          src_use,
        input logic [RW-1:0] ex_rd,
        input logic          ex_we,
        input logic [RW-1:0] mem_rd,
        input logic          mem_we,
        input logic [RW-1:0] wb_rd,
        input logic          wb_we
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!src_use || (src == REG_ZERO)) begin
            sel = SEL_RF;
        end else if (ex_we && (ex_rd == src)) begin
            // A load in EX also lands here; that only happens while the
            // stall bubble is being inserted, when the operand is unused.
            sel = SEL_EX;
        end else if (mem_we && (mem_rd == src)) begin
            sel = SEL_MEM;
        end else if (wb_we && (wb_rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Operand forwarding selects, zero latency from the ID register indices
    always_comb begin
        fw_a_sel_s = fw_select(id_ra, id_ra_use, ex_rd_r, ex_we_r,
                               mem_rd_r, mem_we_r, wb_rd_r, wb_we_r);
        fw_b_sel_s = fw_select(id_rb, id_rb_use, ex_rd_r, ex_we_r,
                               mem_rd_r, mem_we_r, wb_rd_r, wb_we_r);
    end

    // Load-use detection: a load in EX writing a register the ID op reads
    always_comb begin
        ldu_s = 1'b0;
        if ((LOAD_USE_STL != 0) && ex_we_r && ex_ld_r && (ex_rd_r != REG_ZERO)) begin
            ldu_s = (id_ra_use && (id_ra == ex_rd_r)) ||
                    (id_rb_use && (id_rb == ex_rd_r));
        end else begin
            ldu_s = 1'b0;
        end
    end

    // Stall FSM next-state and pipeline control; a taken jump overrides a stall
    always_comb begin
        state_next_s = state_r;
        cu_nop_s     = 1'b0;
        pc_le_s      = 1'b1;
        if_id_le_s   = 1'b1;
        case (state_r)
            ST_RUN: begin
                if (ldu_s && !jump_taken) begin
                    state_next_s = ST_STALL;
                    cu_nop_s     = 1'b1;
                    pc_le_s      = 1'b0;
                    if_id_le_s   = 1'b0;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STALL: begin
                // The load has moved to MEM and now forwards via the MEM path.
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Stall FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow pipe shift; EX takes a bubble whenever MUX_CU zeroes the controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_r  <= REG_ZERO;
            ex_we_r  <= 1'b0;
            ex_ld_r  <= 1'b0;
            mem_rd_r <= REG_ZERO;
            mem_we_r <= 1'b0;
            wb_rd_r  <= REG_ZERO;
            wb_we_r  <= 1'b0;
        end else begin
            wb_rd_r  <= mem_rd_r;
            wb_we_r  <= mem_we_r;
            mem_rd_r <= ex_rd_r;
            mem_we_r <= ex_we_r;
            if (cu_nop_s) begin
                ex_rd_r <= REG_ZERO;
                ex_we_r <= 1'b0;
                ex_ld_r <= 1'b0;
            end else begin
                ex_rd_r <= id_rd;
                ex_we_r <= id_rf_le;
                ex_ld_r <= id_load;
            end
        end
    end

    // Saturating stall counter: one count per bubble-insertion cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (cu_nop_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating flush counter: one count per taken-jump cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (jump_taken && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Forwarding and pipeline controls must be combinational to act in the
    // same cycle. The reset gating holds the documented idle values even
    // while jump_taken is driven during reset.
    assign fw_a_sel  = rst_n ? fw_a_sel_s : SEL_RF;
    assign fw_b_sel  = rst_n ? fw_b_sel_s : SEL_RF;
    assign cu_nop    = cu_nop_s & rst_n;
    assign pc_le     = pc_le_s | ~rst_n;
    assign if_id_le  = if_id_le_s | ~rst_n;
    assign if_flush  = jump_taken & rst_n;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios
// plus randomized instruction streams compared against a reference model
// that tracks the last three issued instructions as a simple history array.

module tb_hazard_forward_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_ra, id_rb, id_rd;
    logic        id_ra_use, id_rb_use, id_rf_le, id_load, jump_taken;
    logic [1:0]  fw_a_sel, fw_b_sel;
    logic        cu_nop, pc_le, if_id_le, if_flush;
    logic [15:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB
    logic [4:0] m_rd [3];
    bit         m_we [3];
    bit         m_ld [3];
    bit         m_stalled;
    int         m_scnt, m_fcnt;

    // Last observed DUT values, used by the directed checks
    logic [1:0]  obs_a, obs_b;
    logic        obs_cu, obs_pc, obs_ifid, obs_flush;
    logic [15:0] obs_scnt, obs_fcnt;

    hazard_forward_unit #(.RW(5), .CNT_W(16), .LOAD_USE_STL(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_ra_use  (id_ra_use),
        .id_rb_use  (id_rb_use),
        .id_rd      (id_rd),
        .id_rf_le   (id_rf_le),
        .id_load    (id_load),
        .jump_taken (jump_taken),
        .fw_a_sel   (fw_a_sel),
        .fw_b_sel   (fw_b_sel),
        .cu_nop     (cu_nop),
        .pc_le      (pc_le),
        .if_id_le   (if_id_le),
        .if_flush   (if_flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 5'd0;
            m_we[i] = 1'b0;
            m_ld[i] = 1'b0;
        end
        m_stalled = 1'b0;
        m_scnt    = 0;
        m_fcnt    = 0;
    endfunction

    // Most recent in-flight writer of src wins; r0 and unused sources read the RF
    function automatic logic [1:0] exp_sel(input logic [4:0] src, input bit src_use);
        if (!src_use || src == 5'd0) return 2'd0;
        for (int i = 0; i < 3; i++)
            if (m_we[i] && m_rd[i] == src) return 2'(i + 1);
        return 2'd0;
    endfunction

    // One pipeline cycle: drive ID/EX inputs, check outputs, advance the model
    task automatic cyc(input logic [4:0] ra, input logic [4:0] rb, input bit ua, input bit ub,
                       input logic [4:0] rd, input bit le, input bit ld, input bit jt, input bit chk);
        bit ldu, stall_now;
        @(negedge clk);
        id_ra = ra; id_rb = rb; id_ra_use = ua; id_rb_use = ub;
        id_rd = rd; id_rf_le = le; id_load = ld; jump_taken = jt;
        #1;
        ldu = m_we[0] && m_ld[0] && m_rd[0] != 5'd0 &&
              ((ua && ra == m_rd[0]) || (ub && rb == m_rd[0]));
        stall_now = !m_stalled && ldu && !jt;
        obs_a = fw_a_sel; obs_b = fw_b_sel; obs_cu = cu_nop; obs_pc = pc_le;
        obs_ifid = if_id_le; obs_flush = if_flush; obs_scnt = stall_cnt; obs_fcnt = flush_cnt;
        if (chk) begin
            check("fw_a_sel", 32'(fw_a_sel), 32'(exp_sel(ra, ua)));
            check("fw_b_sel", 32'(fw_b_sel), 32'(exp_sel(rb, ub)));
            check("cu_nop",   32'(cu_nop),   32'(stall_now));
            check("pc_le",    32'(pc_le),    32'(!stall_now));
            check("if_id_le", 32'(if_id_le), 32'(!stall_now));
            check("if_flush", 32'(if_flush), 32'(jt));
            check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
            check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
        end
        @(posedge clk);
        #1;
        m_rd[2] = m_rd[1]; m_we[2] = m_we[1]; m_ld[2] = m_ld[1];
        m_rd[1] = m_rd[0]; m_we[1] = m_we[0]; m_ld[1] = m_ld[0];
        if (stall_now) begin
            m_rd[0] = 5'd0; m_we[0] = 1'b0; m_ld[0] = 1'b0;
        end else begin
            m_rd[0] = rd; m_we[0] = le; m_ld[0] = ld;
        end
        m_stalled = stall_now;
        if (stall_now && m_scnt < 65535) m_scnt++;
        if (jt && m_fcnt < 65535) m_fcnt++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        jump_taken = 1'b1;
        #1;
        check("rst_fw_a", 32'(fw_a_sel), 32'd0);
        check("rst_if_flush", 32'(if_flush), 32'd0);
        check("rst_pc_le", 32'(pc_le), 32'd1);
        @(negedge clk);
        jump_taken = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b1;
        id_ra = 5'd0; id_rb = 5'd0; id_rd = 5'd0;
        id_ra_use = 1'b0; id_rb_use = 1'b0; id_rf_le = 1'b0; id_load = 1'b0;
        jump_taken = 1'b0;
        model_reset();
        apply_reset();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);

        // T1: back-to-back dependency forwards from EX
        cyc(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 1);
        cyc(5'd3, 5'd3, 1, 1, 5'd8, 1, 0, 0, 1);
        check("T1_a", 32'(obs_a), 32'd1);
        check("T1_b", 32'(obs_b), 32'd1);
        check("T1_nostall", 32'(obs_cu), 32'd0);

        // T2: distance 3 forwards from WB, distance 2 from MEM
        cyc(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 1);
        cyc(5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0, 1);
        cyc(5'd1, 5'd2, 1, 1, 5'd10, 1, 0, 0, 1);
        cyc(5'd5, 5'd2, 1, 1, 5'd11, 1, 0, 0, 1);
        check("T2_wb", 32'(obs_a), 32'd3);
        cyc(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 1);
        cyc(5'd1, 5'd2, 1, 1, 5'd12, 1, 0, 0, 1);
        cyc(5'd2, 5'd5, 1, 1, 5'd13, 1, 0, 0, 1);
        check("T2_mem", 32'(obs_b), 32'd2);

        // T3: load-use inserts one bubble, then forwards from MEM
        cyc(5'd1, 5'd2, 1, 1, 5'd7, 1, 1, 0, 1);
        cyc(5'd7, 5'd2, 1, 1, 5'd14, 1, 0, 0, 1);
        check("T3_cu_nop", 32'(obs_cu), 32'd1);
        check("T3_pc_le", 32'(obs_pc), 32'd0);
        check("T3_if_id_le", 32'(obs_ifid), 32'd0);
        cyc(5'd7, 5'd2, 1, 1, 5'd14, 1, 0, 0, 1);
        check("T3_sel_mem", 32'(obs_a), 32'd2);
        check("T3_no_restall", 32'(obs_cu), 32'd0);
        check("T3_stall_cnt", 32'(obs_scnt), 32'd1);

        // T4: r0 never forwarded or stalled on; EX has priority among writers
        cyc(5'd1, 5'd2, 1, 1, 5'd0, 1, 1, 0, 1);
        cyc(5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0, 1);
        check("T4_r0_sel", 32'(obs_a), 32'd0);
        check("T4_r0_stall", 32'(obs_cu), 32'd0);
        cyc(5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 0, 1);
        cyc(5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 0, 1);
        cyc(5'd4, 5'd4, 1, 0, 5'd15, 1, 0, 0, 1);
        check("T4_ex_prio", 32'(obs_a), 32'd1);
        check("T4_unused_b", 32'(obs_b), 32'd0);

        // Load-use and a taken jump together: jump wins
        cyc(5'd1, 5'd2, 1, 1, 5'd6, 1, 1, 0, 1);
        cyc(5'd6, 5'd2, 1, 1, 5'd16, 1, 0, 1, 1);
        check("jump_wins_cu", 32'(obs_cu), 32'd0);
        check("jump_wins_flush", 32'(obs_flush), 32'd1);

        // Randomized instruction stream over a small register set
        for (int i = 0; i < 2000; i++) begin
            cyc(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), bit'($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 7) == 0), 1);
        end

        // T5: flush counting and saturation at all-ones
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        check("T5_if_flush", 32'(obs_flush), 32'd1);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        check("T5_flush_inc", 32'(obs_fcnt), 32'(m_fcnt));
        while (m_fcnt < 65534) cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        check("T5_fffe", 32'(obs_fcnt), 32'hFFFE);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        check("T5_ffff", 32'(obs_fcnt), 32'hFFFF);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        check("T5_hold", 32'(obs_fcnt), 32'hFFFF);

        // T6: asynchronous reset while in STALL
        cyc(5'd1, 5'd2, 1, 1, 5'd7, 1, 1, 0, 1);
        cyc(5'd7, 5'd7, 1, 1, 5'd14, 1, 0, 0, 1);
        check("T6_stalled", 32'(obs_cu), 32'd1);
        @(negedge clk);
        jump_taken = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("T6_fw_a", 32'(fw_a_sel), 32'd0);
        check("T6_fw_b", 32'(fw_b_sel), 32'd0);
        check("T6_cu_nop", 32'(cu_nop), 32'd0);
        check("T6_pc_le", 32'(pc_le), 32'd1);
        check("T6_if_id_le", 32'(if_id_le), 32'd1);
        check("T6_if_flush", 32'(if_flush), 32'd0);
        check("T6_stall_cnt", 32'(stall_cnt), 32'd0);
        check("T6_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        jump_taken = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cyc(5'd7, 5'd7, 1, 1, 5'd3, 1, 0, 0, 1);
        check("T6_post_sel", 32'(obs_a), 32'd0);
        check("T6_post_cu", 32'(obs_cu), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
